alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that borrows the shared datapath ALU (ADD, ALUctrl 3'b000) to compute a WIDTH-bit unsigned shift-add product.
- Provides MUL-low results without adding a dedicated multiplier.
- Sits beside the execute stage.
- While busy it asserts alu_sel so the datapath ALU operand mux selects its operands, and it captures ALUResult each step.
- Requester and consumer sides use valid/ready handshakes.

---
 rtl/alu_mul_sequencer_if.sv | 38 +++
 rtl/alu_mul_sequencer.sv | 93 +++++++++
 tb/tb_alu_mul_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Handshake and shared-ALU bundle for alu_mul_sequencer.
// Requester side: req_valid/req_ready/op_a/op_b and abort.
// Consumer side: resp_valid/resp_ready/resp_result.
// Shared ALU side: alu_sel/alu_src_a/alu_src_b/alu_ctrl out, alu_result back.
// Valid/ready: a transfer happens on a rising clk edge where both valid and
// ready are 1. The sender keeps its payload stable while valid is high and
// ready is low. The receiver may raise or lower ready freely.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             abort;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             alu_sel;
    logic [WIDTH-1:0] alu_src_a;
    logic [WIDTH-1:0] alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    // Sequencer side
    modport slave (
        input  req_valid, op_a, op_b, abort, resp_ready, alu_result,
        output req_ready, resp_valid, resp_result,
        output alu_sel, alu_src_a, alu_src_b, alu_ctrl
    );

    // Requester / consumer / datapath side
    modport master (
        output req_valid, op_a, op_b, abort, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result,
        input  alu_sel, alu_src_a, alu_src_b, alu_ctrl
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add unsigned multiplier (low WIDTH bits) that
// borrows the shared datapath ALU in ADD mode, one partial product per cycle.
// Optional macro ALU_MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining
// multiplier bits above bit 0 are all zero, instead of always taking WIDTH steps.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    alu_mul_sequencer_if.slave  bus,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

    // Last RUN step: the counter reaches WIDTH-1, or (early exit) no set
    // multiplier bits remain above the one consumed this cycle.
`ifdef ALU_MUL_EARLY_EXIT_EN
    assign last_step = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

    // Handshake and ALU request outputs are pure decodes of the state, so the
    // ALU is only ever claimed while RUN is the registered state.
    assign bus.req_ready   = (state == S_IDLE);
    assign bus.resp_valid  = (state == S_DONE);
    assign bus.resp_result = acc;
    assign bus.alu_sel     = (state == S_RUN);
    assign bus.alu_src_a   = (state == S_RUN) ? acc   : '0;
    assign bus.alu_src_b   = (state == S_RUN) ? mcand : '0;
    assign bus.alu_ctrl    = 3'b000;
    assign state_dbg       = state;

    // Control FSM plus shift-add datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort is meaningless here; a request is still taken.
                    if (bus.req_valid) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        // alu_result is acc + mcand from the shared ALU this cycle.
                        if (mplier[0]) begin
                            acc <= bus.alu_result;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (last_step) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // abort wins over a simultaneous consumer handshake.
                    if (bus.abort || bus.resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed corner cases plus
// randomized multiplies, scored against a plain-arithmetic product and
// latency model.
module tb_alu_mul_sequencer;
    localparam int WIDTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus();

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Shared execute-stage ALU: operand mux honours alu_sel, ctrl 000 = ADD.
    // When not selected it carries unrelated execute-stage traffic.
    assign bus.alu_result = (bus.alu_sel && bus.alu_ctrl == 3'b000)
                            ? bus.alu_src_a + bus.alu_src_b
                            : 32'hA5A5_5A5A;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] full;
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return full[WIDTH-1:0];
    endfunction

    function automatic int ref_run_cycles(input logic [WIDTH-1:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int hi;
        hi = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) hi = i + 1;
        end
        return (hi < 1) ? 1 : hi;
`else
        return (b === b) ? WIDTH : WIDTH;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"},  64'(bus.resp_valid),  64'd0);
        check({tag, "_resp_result"}, 64'(bus.resp_result), 64'd0);
        check({tag, "_alu_sel"},     64'(bus.alu_sel),     64'd0);
        check({tag, "_alu_src_a"},   64'(bus.alu_src_a),   64'd0);
        check({tag, "_alu_src_b"},   64'(bus.alu_src_b),   64'd0);
        check({tag, "_alu_ctrl"},    64'(bus.alu_ctrl),    64'd0);
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic send_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.req_valid = 1'b1;
        exp_q.push_back(ref_product(a, b));
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
    endtask

    // Starts at the negedge of T+1; returns at the negedge where resp_valid is seen.
    task automatic wait_resp(input logic [WIDTH-1:0] b);
        int run;
        int cyc;
        run = 0;
        cyc = 1;
        check("alu_sel_first", 64'(bus.alu_sel), 64'd1);
        check("alu_ctrl_run",  64'(bus.alu_ctrl), 64'd0);
        while (!bus.resp_valid && cyc < 200) begin
            if (bus.alu_sel) run++;
            @(negedge clk);
            cyc++;
        end
        check("resp_timeout", 64'(bus.resp_valid), 64'd1);
        check("run_cycles",   64'(run), 64'(ref_run_cycles(b)));
        check("resp_latency", 64'(cyc), 64'(ref_run_cycles(b) + 1));
        check("alu_sel_done", 64'(bus.alu_sel), 64'd0);
    endtask

    // Holds off the consumer for bp cycles, then takes the response.
    task automatic take_resp(input int bp);
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] exp;
        held = bus.resp_result;
        exp  = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("resp_result", 64'(held), 64'(exp));
        for (int i = 0; i < bp; i++) begin
            bus.resp_ready = 1'b0;
            bus.req_valid  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_resp_valid",  64'(bus.resp_valid),  64'd1);
            check("bp_resp_result", 64'(bus.resp_result), 64'(held));
            check("bp_req_ready",   64'(bus.req_ready),   64'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("idle_req_ready",  64'(bus.req_ready),  64'd1);
        check("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic do_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int bp);
        send_req(a, b);
        wait_resp(b);
        take_resp(bp);
    endtask

    // Watch resp_valid for n cycles; it must never rise.
    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.resp_valid) seen++;
            @(negedge clk);
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bus.req_valid  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.abort      = 1'b0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 64'(bus.req_ready), 64'd1);
        check_reset_outputs("post_reset");

        // Basic product with 5 cycles of consumer backpressure.
        do_mul(32'd6, 32'd7, 5);

        // Wrap-around corners and small multipliers.
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_mul(32'h8000_0000, 32'd2, 1);
        do_mul(32'h1234_5678, 32'd2, 0);
        do_mul(32'hDEAD_BEEF, 32'd0, 0);
        do_mul(32'hCAFE_F00D, 32'd1, 2);

        // Reset asserted in RUN cycle 10: outputs drop immediately.
        send_req(32'd11, 32'h8000_000D);
        repeat (9) @(negedge clk);
        check("pre_reset_alu_sel", 64'(bus.alu_sel), 64'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_mul(32'd3, 32'd5, 0);

        // Abort in RUN cycle 10: no response, then a normal operation.
        send_req(32'd6, 32'h8000_0007);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        void'(exp_q.pop_back());
        check("abort_run_req_ready", 64'(bus.req_ready), 64'd1);
        check("abort_run_alu_sel",   64'(bus.alu_sel),   64'd0);
        expect_quiet("abort_run_no_resp", 40);
        do_mul(32'd3, 32'd5, 0);

        // Abort together with resp_ready in DONE: exactly no response.
        send_req(32'd9, 32'd9);
        wait_resp(32'd9);
        void'(exp_q.pop_back());
        bus.abort      = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.abort      = 1'b0;
        bus.resp_ready = 1'b0;
        check("abort_done_req_ready",  64'(bus.req_ready),  64'd1);
        check("abort_done_resp_valid", 64'(bus.resp_valid), 64'd0);
        expect_quiet("abort_done_no_resp", 5);

        // Abort in IDLE coinciding with a request: request still accepted.
        bus.abort = 1'b1;
        send_req(32'd21, 32'd2);
        bus.abort = 1'b0;
        wait_resp(32'd2);
        take_resp(0);

        // Randomized operands with mixed multiplier shapes and backpressure.
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = $urandom;
                1:       b = WIDTH'($urandom_range(0, 15));
                default: b = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            endcase
            do_mul(a, b, $urandom_range(0, 4));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
